// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Single-port RAM arbiter sitting directly below the icache and dcache.
//   One requester at a time is granted the RAM. The dcache has priority, and a
//   streak limit stops it from starving the icache. RAM errors are reissued up
//   to RETRY_MAX times before a forced completion is flagged on bus_err.
//
// Ports
//   CLK, RST               clock (rising edge), asynchronous active-high reset
//   iREN, iaddr            icache read request / address
//   iwait, iload           icache wait (low on the completing cycle) / read data
//   dREN, dWEN             dcache read / write request (write wins)
//   daddr, dstore          dcache address / write data
//   dwait, dload           dcache wait (low on the completing cycle) / read data
//   ramREN, ramWEN         RAM read / write enables
//   ramaddr, ramstore      RAM address / write data
//   ramload, ramstate      RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   bus_err                one-cycle pulse on a forced completion after retries
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4,
  parameter int RETRY_MAX    = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              bus_err
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SW = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_next;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_next;
  logic          w_d_req;
  logic          w_retries_left;
  logic          w_streak_full;

  // Read data is a straight pass-through; the wait lines say when it is valid.
  assign iload = ramload;
  assign dload = ramload;

  assign w_d_req        = dREN | dWEN;
  assign w_retries_left = (r_retry < RW'(RETRY_MAX));
  assign w_streak_full  = (r_streak == SW'(D_STREAK_MAX));

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the block leaves a signal unassigned (no latches).
    w_state_next  = r_state;
    w_streak_next = iREN ? r_streak : '0;  // any cycle without iREN ends the streak
    w_retry_next  = r_retry;
    iwait         = 1'b1;
    dwait         = 1'b1;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    bus_err       = 1'b0;

    unique case (r_state)
      IDLE: begin
        // The dcache yields once only when it has filled its streak while the
        // icache is waiting.
        if (w_d_req && !(iREN && w_streak_full)) begin
          w_state_next = DGNT;
        end else if (iREN) begin
          w_state_next = IGNT;
        end
      end

      DGNT: begin
        // Bus signals are live copies of the dcache request, not latched.
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_d_req) begin
          w_state_next = IDLE;
          w_retry_next = '0;
        end else if (ramstate == RAM_ACCESS) begin
          dwait        = 1'b0;
          w_state_next = IDLE;
          w_retry_next = '0;
          if (iREN && !w_streak_full) begin
            w_streak_next = r_streak + SW'(1);
          end
        end else if (ramstate == RAM_ERROR) begin
          if (w_retries_left) begin
            w_retry_next = r_retry + RW'(1);
          end else begin
            dwait        = 1'b0;
            bus_err      = 1'b1;
            w_state_next = IDLE;
            w_retry_next = '0;
          end
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          w_state_next = IDLE;
          w_retry_next = '0;
        end else if (ramstate == RAM_ACCESS) begin
          iwait         = 1'b0;
          w_state_next  = IDLE;
          w_retry_next  = '0;
          w_streak_next = '0;
        end else if (ramstate == RAM_ERROR) begin
          if (w_retries_left) begin
            w_retry_next = r_retry + RW'(1);
          end else begin
            iwait         = 1'b0;
            bus_err       = 1'b1;
            w_state_next  = IDLE;
            w_retry_next  = '0;
            w_streak_next = '0;
          end
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (RST) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_retry  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_streak <= w_streak_next;
      r_retry  <= w_retry_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int RMAX = 3;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dstore, ramload;
  logic [1:0]    ramstate;
  logic          iwait, dwait, ramREN, ramWEN, bus_err;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ilow   = 0;
  int n_dlow   = 0;
  string evlog = "";

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .D_STREAK_MAX(SMAX), .RETRY_MAX(RMAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who owns the RAM, how many dcache completions in a row
  // happened while the icache waited, and how many reissues were spent.
  // ---------------------------------------------------------------------------
  localparam int OWN_NONE = 0;
  localparam int OWN_D    = 1;
  localparam int OWN_I    = 2;

  int m_owner  = OWN_NONE;
  int m_streak = 0;
  int m_retry  = 0;

  typedef struct packed {
    logic          iwait;
    logic          dwait;
    logic          ren;
    logic          wen;
    logic          berr;
    logic [AW-1:0] addr;
    logic [DW-1:0] store;
  } exp_t;

  function automatic exp_t expect_now();
    exp_t e;
    bit   forced;
    e       = '0;
    e.iwait = 1'b1;
    e.dwait = 1'b1;
    forced  = (ramstate == ERROR) && (m_retry == RMAX);
    if (m_owner == OWN_D) begin
      e.addr  = daddr;
      e.store = dstore;
      if (dREN || dWEN) begin
        e.wen = dWEN;
        e.ren = !dWEN && dREN;
        if (ramstate == ACCESS || forced) e.dwait = 1'b0;
        e.berr = forced;
      end
    end else if (m_owner == OWN_I) begin
      e.addr = iaddr;
      if (iREN) begin
        e.ren = 1'b1;
        if (ramstate == ACCESS || forced) e.iwait = 1'b0;
        e.berr = forced;
      end
    end
    return e;
  endfunction

  always @(posedge CLK or posedge RST) begin
    exp_t e;
    if (RST) begin
      m_owner  = OWN_NONE;
      m_streak = 0;
      m_retry  = 0;
    end else begin
      e = expect_now();
      if (m_owner == OWN_NONE) begin
        if ((dREN || dWEN) && !(iREN && m_streak == SMAX)) m_owner = OWN_D;
        else if (iREN) m_owner = OWN_I;
      end else if (m_owner == OWN_D) begin
        if (!(dREN || dWEN)) begin
          m_owner = OWN_NONE; m_retry = 0;
        end else if (!e.dwait) begin
          m_owner = OWN_NONE; m_retry = 0;
          if (ramstate == ACCESS) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
        end else if (ramstate == ERROR) begin
          m_retry++;
        end
      end else begin
        if (!iREN) begin
          m_owner = OWN_NONE; m_retry = 0;
        end else if (!e.iwait) begin
          m_owner = OWN_NONE; m_retry = 0; m_streak = 0;
        end else if (ramstate == ERROR) begin
          m_retry++;
        end
      end
      if (!iREN) m_streak = 0;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    e = expect_now();
    check("iwait",    iwait,    e.iwait);
    check("dwait",    dwait,    e.dwait);
    check("ramREN",   ramREN,   e.ren);
    check("ramWEN",   ramWEN,   e.wen);
    check("bus_err",  bus_err,  e.berr);
    check("ramaddr",  ramaddr,  e.addr);
    check("ramstore", ramstore, e.store);
    check("iload",    iload,    ramload);
    check("dload",    dload,    ramload);
    check("waits_not_both_low", iwait | dwait, 1'b1);
    if (!dwait) begin n_dlow++; evlog = {evlog, "D"}; end
    if (!iwait) begin n_ilow++; evlog = {evlog, "I"}; end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ilow0, dlow0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'h0; ramstate = FREE;

    // Reset state
    tick(); tick();
    check("rst_iwait",  iwait,  1'b1);
    check("rst_dwait",  dwait,  1'b1);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    RST = 1'b0;

    // 1: icache read, two BUSY cycles, then ACCESS
    tick(); iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    settle(); check("t1_ren_pre", ramREN, 1'b0);
    tick(); settle();
    check("t1_ren_grant", ramREN, 1'b1);
    check("t1_addr", ramaddr, 32'h40);
    check("t1_iwait_busy", iwait, 1'b1);
    tick(); settle(); check("t1_iwait_busy2", iwait, 1'b1);
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check("t1_iwait_done", iwait, 1'b0);
    check("t1_iload", iload, 32'hDEADBEEF);
    tick(); iREN = 0; ramstate = FREE;
    settle(); check("t1_iwait_after", iwait, 1'b1);

    // 2: simultaneous iREN and dWEN -> dcache first, bubble, then icache
    tick(); iREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = ACCESS;
    settle(); check("t2_idle_wen", ramWEN, 1'b0);
    tick(); settle();
    check("t2_wen", ramWEN, 1'b1);
    check("t2_addr", ramaddr, 32'h80);
    check("t2_store", ramstore, 32'h1234);
    check("t2_dwait", dwait, 1'b0);
    tick(); dWEN = 0;
    settle();
    check("t2_bubble_ren", ramREN, 1'b0);
    check("t2_bubble_wen", ramWEN, 1'b0);
    tick(); settle();
    check("t2_igrant_ren", ramREN, 1'b1);
    check("t2_iwait", iwait, 1'b0);
    tick(); iREN = 0; ramstate = FREE;
    tick();

    // 3: streak limit with both requesters held and RAM always ready
    evlog = "";
    iREN = 1; dREN = 1; ramstate = ACCESS; iaddr = 32'h44; daddr = 32'h88;
    for (int c = 0; c < 40 && evlog.len() < 6; c++) tick();
    if (evlog.len() < 6) check("t3_timeout", evlog.len(), 6);
    else check_str("t3_order", evlog.substr(0, 5), "DDDDID");
    iREN = 0; dREN = 0; ramstate = FREE;
    tick(); tick();

    // 4: ERROR four times -> three reissues, then forced completion
    dREN = 1; ramstate = ERROR; daddr = 32'hC0;
    settle(); check("t4_idle_ren", ramREN, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      check("t4_dwait", dwait, (k == 3) ? 1'b0 : 1'b1);
      check("t4_bus_err", bus_err, (k == 3) ? 1'b1 : 1'b0);
    end
    tick(); dREN = 0; ramstate = FREE;
    settle();
    check("t4_back_idle_ren", ramREN, 1'b0);
    check("t4_berr_clear", bus_err, 1'b0);

    // 5: icache abort while BUSY
    ilow0 = n_ilow;
    tick(); iREN = 1; iaddr = 32'h100; ramstate = BUSY;
    tick(); settle(); check("t5_ren", ramREN, 1'b1);
    tick(); iREN = 0;
    settle();
    check("t5_abort_iwait", iwait, 1'b1);
    check("t5_abort_ren", ramREN, 1'b0);
    tick(); settle();
    check("t5_idle_ren", ramREN, 1'b0);
    check("t5_no_ipulse", n_ilow, ilow0);

    // 6: reset during a BUSY dcache write
    tick(); dWEN = 1; daddr = 32'h99; dstore = 32'h55;
    tick(); settle(); check("t6_wen", ramWEN, 1'b1);
    RST = 1; #1;
    check("t6_rst_wen", ramWEN, 1'b0);
    check("t6_rst_addr", ramaddr, 32'h0);
    check("t6_rst_store", ramstore, 32'h0);
    check("t6_rst_dwait", dwait, 1'b1);
    tick(); RST = 0; ramstate = ACCESS;
    settle(); check("t6_idle_wen", ramWEN, 1'b0);
    tick(); settle();
    check("t6_regrant_dwait", dwait, 1'b0);
    check("t6_regrant_wen", ramWEN, 1'b1);
    check("t6_regrant_addr", ramaddr, 32'h99);
    tick(); dWEN = 0;

    // 7: dREN+dWEN together -> write; then dcache abort while BUSY
    tick(); dREN = 1; dWEN = 1; daddr = 32'h10; dstore = 32'hA5A5;
    tick(); settle();
    check("t7_wen", ramWEN, 1'b1);
    check("t7_ren", ramREN, 1'b0);
    tick(); dWEN = 0; ramstate = BUSY;
    dlow0 = n_dlow;
    tick(); settle();
    check("t7_read_ren", ramREN, 1'b1);
    check("t7_busy_dwait", dwait, 1'b1);
    tick(); dREN = 0;
    settle(); check("t7_abort_dwait", dwait, 1'b1);
    tick(); settle();
    check("t7_no_dpulse", n_dlow, dlow0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
